mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Two-port arbiter and sequencer for the shared 16x16 shift-add `multiplicador` unit. It accepts multiply requests from two independent requesters, for example the ALU/EX stage and the HI/LO multiply path. It grants the multiplier round-robin, drives its `St`/operand inputs, and waits for `Done`. It returns the 32-bit `Produto` to the owning requester with a one-cycle acknowledge. A watchdog aborts a request with an error if the multiplier never completes.

## Interface
- `WIDTH`, 16: operand width; product is 2*WIDTH.
- `TIMEOUT`, 64: max cycles spent in WAIT before abort; legal range 2..255.
- `Clk` in 1: single clock; all state changes on rising edge.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `Req0`, `Req1` in 1: request level; held high with stable operands until the matching `Ack`.
- `Op0_A`, `Op0_B`, `Op1_A`, `Op1_B` in WIDTH: multiplier / multiplicand per requester.
- `Ack0`, `Ack1` out 1: one-cycle completion pulse.
- `Res0`, `Res1` out 2*WIDTH: result; loaded only on the matching `Ack`, holds otherwise.
- `Err0`, `Err1` out 1: valid with `Ack`; 1 = timed out, and then `Res` = 0.
- `St` out 1: start pulse to multiplier.
- `Multiplicador`, `Multiplicando` out WIDTH: registered operands to multiplier.
- `Idle`, `Done` in 1: multiplier status; `Done` is a one-cycle pulse.
- `Produto` in 2*WIDTH: multiplier result, valid while `Done`=1.
- `Busy` out 1: high in every state except IDLE.
- `Owner` out 1: index of the current or last granted requester.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if (`Req0`|`Req1`) and `Idle`=1, select the winner, latch its operands into `Multiplicador`/`Multiplicando`, set `Owner`, then go to START. If `Idle`=0, stay in IDLE regardless of requests.
- Arbitration: round-robin pointer `last`. On a conflict the requester ≠ `last` wins. A single requester always wins. Reset sets `last`=1, so `Req0` wins the first conflict.
- START: `St`=1 for exactly this one cycle, then go to WAIT and clear the watchdog counter.
- WAIT: operands held constant.
  - `Done`=1: capture `Produto` into the owner's `Res`, set `Err`=0, go to RESP.
  - Counter reaches TIMEOUT-1 without `Done`: go to RESP with `Err`=1 and `Res`=0.
  - `Done` and timeout in the same cycle: `Done` wins.
- RESP: `Ack[Owner]`=1 for one cycle, `last`←`Owner`, go to IDLE. The non-owner `Ack`, `Res` and `Err` are unchanged.
- A `Done` pulse outside WAIT is ignored, including a late `Done` after a timeout. The `Idle` gating in IDLE prevents restarting a still-busy unit.
- `Req` deassertion while not owned: simply ignored. Deassertion by the owner before `Ack` is a protocol violation; the arbiter completes the operation anyway.
- Arithmetic: unsigned, with no truncation; `Res` = `Produto` verbatim.

## Timing
- Reset (async assert, any state): FSM→IDLE, `last`=1. All of the following go to 0 immediately: `St`, `Multiplicador`, `Multiplicando`, `Ack0`, `Ack1`, `Res0`, `Res1`, `Err0`, `Err1`, `Busy`, `Owner`. Reset asserted mid-WAIT discards the operation and produces no `Ack`.
- Grant latency: `Req` sampled high in IDLE with `Idle`=1 at edge N → `St` high during cycle N+1.
- Completion: `Done` high in cycle M → `Ack`/`Res` valid in cycle M+1.
- The requester drops `Req` after the edge on which it samples `Ack`. The arbiter re-samples requests at the edge after RESP, so there is no double service.
- Back-to-back service: minimum 1 IDLE cycle between RESP and the next START. Per-request overhead is 3 cycles plus multiplier latency.
- Timeout `Ack` occurs exactly TIMEOUT+1 cycles after the `St` cycle.

## Test plan
- Single request: `Req0`, A=2001, B=4001, with a behavioural multiplier (latency 34). Required: one `St` pulse, then `Ack0` one cycle after `Done`, `Res0`=8006001, `Err0`=0, and `Ack1` never asserted.
- Simultaneous `Req0`/`Req1` from reset (3×5, 7×9). Required: `Req0` served first (`Res0`=15), then `Req1` (`Res1`=63). A repeated conflict afterwards is served to `Req0` again only after `Req1`, confirming alternation.
- Max operands: 65535×65535 on `Req1`. Required: `Res1`=0xFFFE0001.
- Timeout: model suppresses `Done`, TIMEOUT=64. Required: `Ack0` with `Err0`=1 and `Res0`=0, 65 cycles after `St`. A late `Done` that follows is ignored.
- `Idle`=0 held for 10 cycles with `Req0` high. Required: no `St` until `Idle` rises; then `St` occurs exactly 1 cycle after that sampling edge.
- `Rst_n` pulsed low mid-WAIT. Required: all outputs 0 immediately and no `Ack`. After release, a pending `Req0` restarts from IDLE and completes correctly.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Bundle between the two requesters, the shared multiplier and the arbiter.
// The arbiter takes the slave modport. The environment (requesters plus multiplier) takes the master modport.
interface mult_arbiter_if #(
    parameter int WIDTH = 16
);
    logic                 Req0;
    logic                 Req1;
    logic [WIDTH-1:0]     Op0_A;
    logic [WIDTH-1:0]     Op0_B;
    logic [WIDTH-1:0]     Op1_A;
    logic [WIDTH-1:0]     Op1_B;
    logic                 Ack0;
    logic                 Ack1;
    logic [2*WIDTH-1:0]   Res0;
    logic [2*WIDTH-1:0]   Res1;
    logic                 Err0;
    logic                 Err1;
    logic                 St;
    logic [WIDTH-1:0]     Multiplicador;
    logic [WIDTH-1:0]     Multiplicando;
    logic                 Idle;
    logic                 Done;
    logic [2*WIDTH-1:0]   Produto;
    logic                 Busy;
    logic                 Owner;

    modport slave (
        input  Req0, Req1, Op0_A, Op0_B, Op1_A, Op1_B,
        input  Idle, Done, Produto,
        output Ack0, Ack1, Res0, Res1, Err0, Err1,
        output St, Multiplicador, Multiplicando, Busy, Owner
    );

    modport master (
        output Req0, Req1, Op0_A, Op0_B, Op1_A, Op1_B,
        output Idle, Done, Produto,
        input  Ack0, Ack1, Res0, Res1, Err0, Err1,
        input  St, Multiplicador, Multiplicando, Busy, Owner
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin two-port sequencer for the shared shift-add multiplier, with a watchdog abort.
// Req->St takes 1 cycle and Done->Ack takes 1 cycle; requesters hold Req until Ack, and a busy unit (Idle=0) stalls the grant.
module mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          Clk,
    input  logic          Rst_n,
    mult_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t             state_q;
    logic               last_q;
    logic               owner_q;
    logic               st_q;
    logic               busy_q;
    logic               ack0_q;
    logic               ack1_q;
    logic               err0_q;
    logic               err1_q;
    logic [WIDTH-1:0]   mcador_q;
    logic [WIDTH-1:0]   mcando_q;
    logic [2*WIDTH-1:0] res0_q;
    logic [2*WIDTH-1:0] res1_q;
    logic [7:0]         wdog_q;

    logic               any_req_d;
    logic               winner_d;
    logic               timeout_d;

    assign any_req_d = bus.Req0 | bus.Req1;
    // On a conflict, the requester that did not win last time gets the unit.
    assign winner_d  = (bus.Req0 & bus.Req1) ? ~last_q : bus.Req1;
    assign timeout_d = (wdog_q == WDOG_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            st_q     <= 1'b0;
            busy_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            mcador_q <= '0;
            mcando_q <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            wdog_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req_d && bus.Idle) begin
                        owner_q  <= winner_d;
                        mcador_q <= winner_d ? bus.Op1_A : bus.Op0_A;
                        mcando_q <= winner_d ? bus.Op1_B : bus.Op0_B;
                        st_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    st_q    <= 1'b0;
                    wdog_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over a watchdog expiry in the same cycle.
                    if (bus.Done) begin
                        if (owner_q) begin
                            res1_q <= bus.Produto;
                            err1_q <= 1'b0;
                            ack1_q <= 1'b1;
                        end else begin
                            res0_q <= bus.Produto;
                            err0_q <= 1'b0;
                            ack0_q <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else if (timeout_d) begin
                        if (owner_q) begin
                            res1_q <= '0;
                            err1_q <= 1'b1;
                            ack1_q <= 1'b1;
                        end else begin
                            res0_q <= '0;
                            err0_q <= 1'b1;
                            ack0_q <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                S_RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.St            = st_q;
    assign bus.Multiplicador = mcador_q;
    assign bus.Multiplicando = mcando_q;
    assign bus.Ack0          = ack0_q;
    assign bus.Ack1          = ack1_q;
    assign bus.Res0          = res0_q;
    assign bus.Res1          = res1_q;
    assign bus.Err0          = err0_q;
    assign bus.Err1          = err1_q;
    assign bus.Busy          = busy_q;
    assign bus.Owner         = owner_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter. It uses a behavioural 34-cycle multiplier with hooks to suppress or inject Done and to hold Idle low.
module tb_mult_arbiter;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 34;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mult_arbiter_if #(.WIDTH(WIDTH)) bus();

    mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural multiplier
    logic               m_busy;
    logic               done_r;
    int                 m_cnt;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] prod_r;
    logic               suppress  = 1'b0;
    logic               idle_hold = 1'b0;
    logic               inj_done  = 1'b0;
    logic [2*WIDTH-1:0] inj_val   = '0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_busy <= 1'b0;
            done_r <= 1'b0;
            m_cnt  <= 0;
            ma     <= '0;
            mb     <= '0;
            prod_r <= '0;
        end else begin
            done_r <= 1'b0;
            if (bus.St && !m_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT - 1;
                ma     <= bus.Multiplicador;
                mb     <= bus.Multiplicando;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    if (!suppress) begin
                        done_r <= 1'b1;
                        prod_r <= {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign bus.Idle    = ~m_busy & ~idle_hold;
    assign bus.Done    = done_r | inj_done;
    assign bus.Produto = inj_done ? inj_val : prod_r;

    // Event monitor
    int st_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, st_cyc = 0, done_cyc = 0;
    always @(negedge Clk) begin
        if (bus.St)   begin st_cnt++; st_cyc = cyc; end
        if (bus.Done) done_cyc = cyc;
        if (bus.Ack0) ack0_cnt++;
        if (bus.Ack1) ack1_cnt++;
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_ack(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (bus.Ack0 || bus.Ack1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_st(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (bus.St) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        tick(); tick();
        checks++; if (bus.St !== 1'b0) begin errors++; $display("FAIL reset_st got %0b want 0", bus.St); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.Busy); end
        checks++; if (bus.Owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %0b want 0", bus.Owner); end
        checks++; if ({bus.Ack0, bus.Ack1, bus.Err0, bus.Err1} !== 4'b0) begin errors++; $display("FAIL reset_ack_err got %b want 0000", {bus.Ack0, bus.Ack1, bus.Err0, bus.Err1}); end
        checks++; if ({bus.Res0, bus.Res1} !== 64'd0) begin errors++; $display("FAIL reset_res got %h/%h want 0/0", bus.Res0, bus.Res1); end
        checks++; if ({bus.Multiplicador, bus.Multiplicando} !== 32'd0) begin errors++; $display("FAIL reset_operands got %h/%h want 0/0", bus.Multiplicador, bus.Multiplicando); end
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int s0, a1;
        s0 = st_cnt; a1 = ack1_cnt;
        bus.Op0_A = 16'd2001; bus.Op0_B = 16'd4001; bus.Req0 = 1'b1;
        wait_ack(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_ack_timeout got none want ack"); end
        checks++; if (bus.Ack0 !== 1'b1) begin errors++; $display("FAIL single_ack0 got %0b want 1", bus.Ack0); end
        checks++; if (bus.Res0 !== 32'd8006001) begin errors++; $display("FAIL single_res0 got %0d want 8006001", bus.Res0); end
        checks++; if (bus.Err0 !== 1'b0) begin errors++; $display("FAIL single_err0 got %0b want 0", bus.Err0); end
        checks++; if (cyc !== done_cyc + 1) begin errors++; $display("FAIL single_ack_latency got %0d want %0d", cyc, done_cyc + 1); end
        checks++; if (st_cnt !== s0 + 1) begin errors++; $display("FAIL single_st_count got %0d want %0d", st_cnt - s0, 1); end
        checks++; if (ack1_cnt !== a1) begin errors++; $display("FAIL single_no_ack1 got %0d want 0", ack1_cnt - a1); end
        checks++; if (bus.Owner !== 1'b0) begin errors++; $display("FAIL single_owner got %0b want 0", bus.Owner); end
        bus.Req0 = 1'b0;
        tick();
        checks++; if (bus.Ack0 !== 1'b0) begin errors++; $display("FAIL single_ack_pulse got %0b want 0", bus.Ack0); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %0b want 0", bus.Busy); end
    endtask

    task automatic test_conflict();
        bit ok;
        Rst_n = 1'b0; tick(); Rst_n = 1'b1; tick();
        bus.Op0_A = 16'd3; bus.Op0_B = 16'd5; bus.Op1_A = 16'd7; bus.Op1_B = 16'd9;
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack0, bus.Ack1} !== 3'b110) begin errors++; $display("FAIL conflict1_first got ok/ack0/ack1=%b want 110", {ok, bus.Ack0, bus.Ack1}); end
        checks++; if (bus.Res0 !== 32'd15) begin errors++; $display("FAIL conflict1_res0 got %0d want 15", bus.Res0); end
        bus.Req0 = 1'b0;
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack0, bus.Ack1} !== 3'b101) begin errors++; $display("FAIL conflict1_second got ok/ack0/ack1=%b want 101", {ok, bus.Ack0, bus.Ack1}); end
        checks++; if (bus.Res1 !== 32'd63) begin errors++; $display("FAIL conflict1_res1 got %0d want 63", bus.Res1); end
        checks++; if (bus.Res0 !== 32'd15) begin errors++; $display("FAIL conflict1_res0_hold got %0d want 15", bus.Res0); end
        bus.Req1 = 1'b0;
        tick();
        // A lone Req0 makes last=0, so the next conflict should go to Req1.
        bus.Op0_A = 16'd2; bus.Op0_B = 16'd3; bus.Req0 = 1'b1;
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack0, bus.Res0} !== {2'b11, 32'd6}) begin errors++; $display("FAIL solo_req0 got ok/ack0=%b%b res0=%0d want 11 6", ok, bus.Ack0, bus.Res0); end
        bus.Req0 = 1'b0;
        tick();
        bus.Op0_A = 16'd4; bus.Op0_B = 16'd5; bus.Op1_A = 16'd6; bus.Op1_B = 16'd7;
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack0, bus.Ack1} !== 3'b101) begin errors++; $display("FAIL conflict2_first got ok/ack0/ack1=%b want 101", {ok, bus.Ack0, bus.Ack1}); end
        checks++; if (bus.Res1 !== 32'd42) begin errors++; $display("FAIL conflict2_res1 got %0d want 42", bus.Res1); end
        bus.Req1 = 1'b0;
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack0, bus.Ack1} !== 3'b110) begin errors++; $display("FAIL conflict2_second got ok/ack0/ack1=%b want 110", {ok, bus.Ack0, bus.Ack1}); end
        checks++; if (bus.Res0 !== 32'd20) begin errors++; $display("FAIL conflict2_res0 got %0d want 20", bus.Res0); end
        bus.Req0 = 1'b0;
        tick();
    endtask

    task automatic test_max();
        bit ok;
        bus.Op1_A = 16'hFFFF; bus.Op1_B = 16'hFFFF; bus.Req1 = 1'b1;
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack1} !== 2'b11) begin errors++; $display("FAIL max_ack1 got ok/ack1=%b want 11", {ok, bus.Ack1}); end
        checks++; if (bus.Res1 !== 32'hFFFE0001) begin errors++; $display("FAIL max_res1 got %h want fffe0001", bus.Res1); end
        checks++; if (bus.Err1 !== 1'b0) begin errors++; $display("FAIL max_err1 got %0b want 0", bus.Err1); end
        checks++; if (bus.Owner !== 1'b1) begin errors++; $display("FAIL max_owner got %0b want 1", bus.Owner); end
        bus.Req1 = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int a0;
        suppress = 1'b1;
        bus.Op0_A = 16'd100; bus.Op0_B = 16'd200; bus.Req0 = 1'b1;
        wait_st(20, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timeout_st got none want St"); end
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack0, bus.Err0} !== 3'b111) begin errors++; $display("FAIL timeout_ack_err got ok/ack0/err0=%b want 111", {ok, bus.Ack0, bus.Err0}); end
        checks++; if (bus.Res0 !== 32'd0) begin errors++; $display("FAIL timeout_res0 got %h want 0", bus.Res0); end
        checks++; if (cyc - st_cyc !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", cyc - st_cyc, TIMEOUT + 1); end
        checks++; if ({bus.Res1, bus.Err1} !== {32'hFFFE0001, 1'b0}) begin errors++; $display("FAIL timeout_other_hold got %h/%0b want fffe0001/0", bus.Res1, bus.Err1); end
        bus.Req0 = 1'b0;
        tick();
        a0 = ack0_cnt;
        inj_val = 32'hDEADBEEF; inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (5) tick();
        checks++; if (ack0_cnt !== a0) begin errors++; $display("FAIL late_done_ack got %0d want 0", ack0_cnt - a0); end
        checks++; if ({bus.Res0, bus.Busy} !== 33'd0) begin errors++; $display("FAIL late_done_state got res0=%h busy=%0b want 0/0", bus.Res0, bus.Busy); end
        suppress = 1'b0;
    endtask

    task automatic test_idle_gate();
        bit ok;
        int s0;
        idle_hold = 1'b1;
        s0 = st_cnt;
        bus.Op0_A = 16'd6; bus.Op0_B = 16'd7; bus.Req0 = 1'b1;
        repeat (10) tick();
        checks++; if (st_cnt !== s0) begin errors++; $display("FAIL idle_gate_no_st got %0d want 0", st_cnt - s0); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL idle_gate_busy got %0b want 0", bus.Busy); end
        idle_hold = 1'b0;
        tick();
        checks++; if (bus.St !== 1'b1) begin errors++; $display("FAIL idle_gate_st_latency got %0b want 1", bus.St); end
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack0, bus.Res0} !== {2'b11, 32'd42}) begin errors++; $display("FAIL idle_gate_res0 got ok/ack0=%b%b res0=%0d want 11 42", ok, bus.Ack0, bus.Res0); end
        bus.Req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int a0;
        bus.Op0_A = 16'd11; bus.Op0_B = 16'd13; bus.Req0 = 1'b1;
        wait_st(20, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstwait_st got none want St"); end
        repeat (5) tick();
        a0 = ack0_cnt;
        Rst_n = 1'b0;
        #1;
        checks++; if ({bus.St, bus.Busy, bus.Owner, bus.Ack0, bus.Ack1, bus.Err0, bus.Err1} !== 7'd0) begin errors++; $display("FAIL rstwait_ctrl got %b want 0000000", {bus.St, bus.Busy, bus.Owner, bus.Ack0, bus.Ack1, bus.Err0, bus.Err1}); end
        checks++; if ({bus.Res0, bus.Res1} !== 64'd0) begin errors++; $display("FAIL rstwait_res got %h/%h want 0/0", bus.Res0, bus.Res1); end
        checks++; if ({bus.Multiplicador, bus.Multiplicando} !== 32'd0) begin errors++; $display("FAIL rstwait_operands got %h/%h want 0/0", bus.Multiplicador, bus.Multiplicando); end
        tick(); tick();
        Rst_n = 1'b1;
        wait_ack(200, ok);
        checks++; if ({ok, bus.Ack0, bus.Err0} !== 3'b110) begin errors++; $display("FAIL rstwait_restart got ok/ack0/err0=%b want 110", {ok, bus.Ack0, bus.Err0}); end
        checks++; if (bus.Res0 !== 32'd143) begin errors++; $display("FAIL rstwait_res0 got %0d want 143", bus.Res0); end
        checks++; if (ack0_cnt !== a0 + 1) begin errors++; $display("FAIL rstwait_ack_count got %0d want 1", ack0_cnt - a0); end
        bus.Req0 = 1'b0;
        tick();
    endtask

    initial begin
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        bus.Op0_A = '0; bus.Op0_B = '0; bus.Op1_A = '0; bus.Op1_B = '0;
        test_reset();
        test_single();
        test_conflict();
        test_max();
        test_timeout();
        test_idle_gate();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion want finish");
        $fatal(1, "bench did not complete");
    end

endmodule
